mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit for the pipelined MIPS core, sitting in the EX stage beside the ALU.
- Owns the HI/LO register pair and sequences each mult/div operation with an internal busy counter.
- The hazard unit stalls any MDU-class instruction while busy or start is high.
- Operands arrive already forwarded; immediates are never used.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU (must be >=1).
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU (must be >=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
- start  input  1  issue strobe for a MULT/MULTU/DIV/DIVU in EX this cycle.
- MDUOp  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- A  input  32  rs operand (dividend / multiplicand / MTHI/MTLO source).
- B  input  32  rt operand (divisor / multiplier).
- busy  output  1  high while an operation is in flight.
- HI  output  32  current HI register (combinational read for MFHI).
- LO  output  32  current LO register (combinational read for MFLO).

Behaviour:
- Reset values: busy=0, HI=0, LO=0, state=IDLE, counter=0, pending result discarded.
- Reset has priority over every other input.
- FSM has two states:
  - IDLE: a rising edge with start=1 and MDUOp in {1..4} does the following:
    - latches the full 64-bit result into pending registers {pend_hi, pend_lo}, computed from A/B sampled at that edge;
    - loads counter with MULT_CYCLES or DIV_CYCLES;
    - moves to RUN with busy=1.
  - RUN: counter decrements each edge. On the edge where counter==1, HI<=pend_hi, LO<=pend_lo, busy<=0, state goes to IDLE.
- Timing: for issue edge T0, busy is high for exactly N full cycles (edges T1..TN-1 remain RUN). The HI/LO update is visible after edge TN. HI/LO hold their old values throughout RUN.
- start with MDUOp in {0,5,6,7} never enters RUN.
- start is ignored while in RUN; no queueing and no restart.
- MTHI/MTLO:
  - Act in IDLE when MDUOp=5 or 6, independent of start.
  - Single-cycle: HI<=A or LO<=A at the edge; busy stays 0.
  - Ignored in RUN, because the hazard unit guarantees they never issue while busy.
- Arithmetic:
  - MULT: signed 32x32 to 64; HI=bits[63:32], LO=bits[31:0].
  - MULTU: unsigned 32x32 to 64, same HI/LO split.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (DIV/DIVU with B=0): the full busy duration still elapses, then HI/LO keep their prior values unchanged.
- Reset mid-operation: the operation is aborted at that edge, all state goes to reset values, and no commit ever occurs.
- Back-to-back: start may be accepted on the same edge that busy falls only if state is already IDLE at that edge. Therefore the earliest new issue is the edge after busy falls.
- Result computation may be combinational at issue time (behavioural operators are allowed). The visible latency is defined solely by the counter.

Test Plan:
- Reset held 2 cycles then released -> busy=0, HI=0, LO=0. Assert reset at cycle 3 of a DIV -> busy=0, HI/LO=0 at the next edge, with no later commit.
- MULT A=0xFFFFFFFF, B=0xFFFFFFFF, start pulse -> busy high exactly 5 cycles, then HI=0x00000000, LO=0x00000001. MULTU with the same operands -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- Preload HI=0x11111111 via MTHI and LO=0x22222222 via MTLO (busy stays 0; values visible next cycle), then DIVU by B=0 -> after 10 busy cycles HI/LO remain 0x11111111/0x22222222.
- MULT issued, then a second start with MULT A=3, B=4 at busy cycle 2 -> ignored. First result commits at cycle 5; a re-issue after busy falls yields LO=12, HI=0.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000. HI/LO read unchanged while busy=1.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit for the EX stage. It owns HI/LO, and a busy
// counter sets the visible latency while the 64-bit result waits in pending registers.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic          pend_ok_q, pend_ok_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic          is_mult, is_div, is_signed, issue;
    logic [63:0]   prod;
    logic          a_neg, b_neg;
    logic [31:0]   dvd, dvs, dvs_safe, q_mag, r_mag, quot, rem;
    logic [31:0]   res_hi, res_lo;

    assign is_mult   = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    assign is_div    = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    assign is_signed = (MDUOp == OP_MULT) || (MDUOp == OP_DIV);
    assign issue     = (state_q == IDLE) && start && (is_mult || is_div);

    // Low 64 bits of the product of extended operands equal the true product.
    always_comb begin
        if (is_signed) begin
            prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        end else begin
            prod = {32'd0, A} * {32'd0, B};
        end
    end

    // Signed division by magnitudes avoids the INT_MIN / -1 corner of native
    // signed divide; a zero divisor is replaced so no X/undefined result appears.
    always_comb begin
        a_neg    = is_signed & A[31];
        b_neg    = is_signed & B[31];
        dvd      = a_neg ? (~A + 32'd1) : A;
        dvs      = b_neg ? (~B + 32'd1) : B;
        dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
        q_mag    = dvd / dvs_safe;
        r_mag    = dvd % dvs_safe;
        quot     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem      = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        if (is_div) begin
            res_hi = rem;
            res_lo = quot;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d   = RUN;
                    cnt_d     = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    pend_ok_d = !(is_div && (B == 32'd0));
                end else if (MDUOp == OP_MTHI) begin
                    hi_d = A;
                end else if (MDUOp == OP_MTLO) begin
                    lo_d = A;
                end
            end
            RUN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (pend_ok_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboarded bench for mult_div_unit: stimulus queues expected HI/LO and busy
// length; a monitor checks each result when busy falls.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  MDUOp = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] HI, LO;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        int          id;
    } exp_t;
    exp_t sb[$];

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int cyc, input int id);
        exp_t e;
        e.hi = hi; e.lo = lo; e.cycles = cyc; e.id = id;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; MDUOp = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; MDUOp = 3'd0; A = 32'd0; B = 32'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            tests++; fails++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", n);
        end
    endtask

    // Monitor: a busy falling edge outside reset is a commit; compare to queue head.
    initial begin
        logic busy_prev = 1'b0;
        int   bcnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_prev = 1'b0;
                bcnt      = 0;
            end else begin
                if (busy) begin
                    bcnt++;
                end else if (busy_prev) begin
                    if (sb.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_commit: HI=0x%08h LO=0x%08h, expected no commit", HI, LO);
                    end else begin
                        e = sb.pop_front();
                        $display("[TB] op%0d: busy=%0d HI=0x%08h LO=0x%08h", e.id, bcnt, HI, LO);
                        check($sformatf("op%0d_hi", e.id), HI, e.hi);
                        check($sformatf("op%0d_lo", e.id), LO, e.lo);
                        check($sformatf("op%0d_busy_cycles", e.id), 32'(bcnt), 32'(e.cycles));
                    end
                    bcnt = 0;
                end
                busy_prev = busy;
            end
        end
    end

    initial begin
        // Reset held two cycles
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        $display("[TB] reset: busy=%0d HI=0x%08h LO=0x%08h", busy, HI, LO);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);

        push(32'h00000000, 32'h00000001, 5, 1);
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();
        push(32'hFFFFFFFE, 32'h00000001, 5, 2);
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();
        push(32'hFFFFFFFF, 32'hFFFFFFFD, 10, 3);
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle();
        push(32'd1, 32'd3, 10, 4);
        issue(3'd4, 32'd7, 32'd2);
        wait_idle();

        // MTHI / MTLO single-cycle writes
        @(negedge clk);
        MDUOp = 3'd5; A = 32'h11111111;
        @(negedge clk);
        $display("[TB] mthi: busy=%0d HI=0x%08h", busy, HI);
        check("mthi_hi", HI, 32'h11111111);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        MDUOp = 3'd6; A = 32'h22222222;
        @(negedge clk);
        $display("[TB] mtlo: busy=%0d LO=0x%08h", busy, LO);
        check("mtlo_lo", LO, 32'h22222222);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        check("mtlo_hi_kept", HI, 32'h11111111);
        MDUOp = 3'd0; A = 32'd0;

        // Divide by zero keeps HI/LO
        push(32'h11111111, 32'h22222222, 10, 5);
        issue(3'd4, 32'd99, 32'd0);
        wait_idle();

        // INT_MIN / -1, HI/LO stable while busy
        push(32'h00000000, 32'h80000000, 10, 6);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("div_busy_hi_hold", HI, 32'h11111111);
            check("div_busy_lo_hold", LO, 32'h22222222);
        end
        wait_idle();

        // Start during RUN is ignored
        push(32'd0, 32'd30, 5, 7);
        issue(3'd1, 32'd5, 32'd6);
        issue(3'd1, 32'd3, 32'd4);
        wait_idle();
        push(32'd0, 32'd12, 5, 8);
        issue(3'd1, 32'd3, 32'd4);
        wait_idle();

        // Reset at busy cycle 3 of a DIV aborts with no later commit
        issue(3'd3, 32'd100, 32'd3);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        $display("[TB] abort: busy=%0d HI=0x%08h LO=0x%08h", busy, HI, LO);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_no_commit_hi", HI, 32'd0);
        check("abort_no_commit_lo", LO, 32'd0);
        check("abort_no_commit_busy", {31'd0, busy}, 32'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
